// File: rtl/gmii_tx_framer_if.sv
// Byte-stream handshake into the GMII transmit framer.
interface gmii_tx_framer_if;
  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic       s_last_i;
  logic       s_ready_o;

  modport master (output s_data_i, s_valid_i, s_last_i, input s_ready_o);
  modport slave  (input s_data_i, s_valid_i, s_last_i, output s_ready_o);
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, optional zero pad, CRC-32 FCS, IFG.
// Define GMII_TX_PAD_EN to pad short frames to MIN_PAYLOAD bytes.
//
// state | meaning
// IDLE  | waiting for s_valid_i, outputs quiet
// PRE   | emitting 0x55 preamble bytes
// SFD   | emitting 0xD5, first payload byte accepted
// DATA  | streaming payload bytes
// PAD   | zero padding up to MIN_PAYLOAD (GMII_TX_PAD_EN only)
// FCS   | emitting the four CRC bytes, LSB first
// DRAIN | aborted frame, discarding bytes until s_last_i
// IFG   | enforced inter-frame gap
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic              clk125_i,
  input  logic              reset_n_i,
  gmii_tx_framer_if.slave   s_if,
  output logic [7:0]        Txd_o,
  output logic              Tx_en_o,
  output logic              Tx_er_o,
  output logic              busy_o,
  output logic              underrun_o,
  output logic [15:0]       frame_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
`ifdef GMII_TX_PAD_EN
    PAD,
`endif
    FCS,
    DRAIN,
    IFG
  } state_e;

  localparam logic [15:0] PRE_LOAD = 16'(PREAMBLE_LEN - 1);
  // Outputs lag the state by one cycle, so the first IFG cycle still carries
  // the last FCS byte; the extra count keeps IFG_BYTES truly idle cycles.
  localparam logic [15:0] IFG_LOAD = 16'(IFG_BYTES);

  state_e      state_q, state_d;
  logic [15:0] tmr_q, tmr_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        underrun_q, underrun_d;
`ifdef GMII_TX_PAD_EN
  localparam logic [10:0] MIN_P = 11'(MIN_PAYLOAD);
  logic [10:0] cnt_q, cnt_d, cnt_inc;
`endif

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    crc_d       = crc_q;
    fcs_idx_d   = fcs_idx_q;
    frame_cnt_d = frame_cnt_q;
    txd_d       = 8'h00;
    tx_en_d     = 1'b0;
    tx_er_d     = 1'b0;
    underrun_d  = 1'b0;
    fcs         = ~crc_q;
`ifdef GMII_TX_PAD_EN
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
`endif
    case (state_q)
      IDLE: begin
        if (s_if.s_valid_i) begin
          state_d   = PRE;
          tmr_d     = PRE_LOAD;
          txd_d     = 8'h55;
          tx_en_d   = 1'b1;
          crc_d     = 32'hFFFF_FFFF;
          fcs_idx_d = 2'd0;
`ifdef GMII_TX_PAD_EN
          cnt_d     = 11'd0;
`endif
        end
      end
      PRE: begin
        tx_en_d = 1'b1;
        if (tmr_q == 16'd0) begin
          txd_d   = 8'hD5;
          state_d = SFD;
        end else begin
          txd_d = 8'h55;
          tmr_d = tmr_q - 16'd1;
        end
      end
      SFD, DATA: begin
        tx_en_d = 1'b1;
        if (s_if.s_valid_i) begin
          txd_d = s_if.s_data_i;
          crc_d = crc32_byte(crc_q, s_if.s_data_i);
`ifdef GMII_TX_PAD_EN
          cnt_d = cnt_inc;
          if (s_if.s_last_i) state_d = (cnt_inc < MIN_P) ? PAD : FCS;
          else               state_d = DATA;
`else
          state_d = s_if.s_last_i ? FCS : DATA;
`endif
        end else begin
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
          state_d    = DRAIN;
        end
      end
`ifdef GMII_TX_PAD_EN
      PAD: begin
        tx_en_d = 1'b1;
        crc_d   = crc32_byte(crc_q, 8'h00);
        cnt_d   = cnt_q + 11'd1;
        if (cnt_q + 11'd1 >= MIN_P) state_d = FCS;
      end
`endif
      FCS: begin
        tx_en_d   = 1'b1;
        txd_d     = fcs[{fcs_idx_q, 3'b000} +: 8];
        fcs_idx_d = fcs_idx_q + 2'd1;
        if (fcs_idx_q == 2'd3) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          tmr_d       = IFG_LOAD;
          state_d     = IFG;
        end
      end
      DRAIN: begin
        if (s_if.s_valid_i && s_if.s_last_i) begin
          tmr_d   = IFG_LOAD;
          state_d = IFG;
        end
      end
      IFG: begin
        if (tmr_q == 16'd0) state_d = IDLE;
        else                tmr_d   = tmr_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk125_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      tmr_q       <= 16'd0;
      crc_q       <= 32'hFFFF_FFFF;
      fcs_idx_q   <= 2'd0;
      frame_cnt_q <= 16'd0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef GMII_TX_PAD_EN
      cnt_q       <= 11'd0;
`endif
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      crc_q       <= crc_d;
      fcs_idx_q   <= fcs_idx_d;
      frame_cnt_q <= frame_cnt_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= tx_er_d;
      underrun_q  <= underrun_d;
`ifdef GMII_TX_PAD_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign s_if.s_ready_o = (state_q == SFD) || (state_q == DATA) || (state_q == DRAIN);
  assign busy_o         = (state_q != IDLE);
  assign Txd_o          = txd_q;
  assign Tx_en_o        = tx_en_q;
  assign Tx_er_o        = tx_er_q;
  assign underrun_o     = underrun_q;
  assign frame_cnt_o    = frame_cnt_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer; build with GMII_TX_PAD_EN to cover padding.
module tb_gmii_tx_framer;

`ifdef GMII_TX_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  gmii_tx_framer_if s_if ();
  logic [7:0]  txd;
  logic        tx_en, tx_er, busy, underrun;
  logic [15:0] frame_cnt;

  gmii_tx_framer dut (
    .clk125_i    (clk),
    .reset_n_i   (rst_n),
    .s_if        (s_if),
    .Txd_o       (txd),
    .Tx_en_o     (tx_en),
    .Tx_er_o     (tx_er),
    .busy_o      (busy),
    .underrun_o  (underrun),
    .frame_cnt_o (frame_cnt)
  );

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pl[$];
  logic [7:0] mon_exp;
  int en_cycles = 0, er_cycles = 0, er_bad = 0, und_cnt = 0;
  int low_run = 0, last_gap = 0;
  logic [15:0] exp_frames = 16'd0;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int j = 0; j < 8; j++) begin
      fb = r[0] ^ b[j];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  function automatic int exp_len(input int n);
    return 8 + ((PAD_ON && n < 60) ? 60 : n) + 4;
  endfunction

  function automatic void push_frame(input int nbytes, input bit with_tail);
    logic [31:0] crc;
    int total;
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < nbytes; i++) begin
      exp_q.push_back(pl[i]);
      crc = crc_upd(crc, pl[i]);
    end
    if (with_tail) begin
      total = nbytes;
      while (PAD_ON && total < 60) begin
        exp_q.push_back(8'h00);
        crc = crc_upd(crc, 8'h00);
        total++;
      end
      crc = ~crc;
      for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (underrun) und_cnt++;
      if (tx_en) begin
        en_cycles++;
        if (low_run > 0) last_gap = low_run;
        low_run = 0;
        if (tx_er) begin
          er_cycles++;
          if (txd !== 8'h00) er_bad++;
        end else begin
          vectors++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream: Txd_o=%02h while scoreboard empty", txd);
          end else begin
            mon_exp = exp_q.pop_front();
            if (txd !== mon_exp) begin
              errors++;
              $display("FAIL stream: Txd_o=%02h expected %02h", txd, mon_exp);
            end
          end
        end
      end else begin
        low_run++;
        if (tx_er) er_cycles++;
      end
    end
  end

  task automatic fill_payload(input int n, input int seed);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'((seed + i * 7) ^ $urandom_range(0, 255)));
  endtask

  task automatic drive_frame(input int drop_after);
    int n;
    int t;
    n = pl.size();
    for (int i = 0; i < n; i++) begin
      if (i == drop_after) begin
        s_if.s_valid_i = 1'b0;
        s_if.s_last_i  = 1'b0;
        @(posedge clk); #1;
      end
      s_if.s_data_i  = pl[i];
      s_if.s_valid_i = 1'b1;
      s_if.s_last_i  = (i == n - 1);
      t = 0;
      while (1) begin
        @(negedge clk);
        if (s_if.s_ready_o) break;
        t++;
        if (t > 2000) begin
          vectors++; errors++;
          $display("FAIL handshake_timeout: byte %0d never accepted", i);
          return;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      vectors++; errors++;
      $display("FAIL done_timeout: busy=%0b pending=%0d expected idle", busy, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    s_if.s_valid_i = 1'b1;
    s_if.s_last_i  = 1'b0;
    s_if.s_data_i  = 8'hA5;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({txd, tx_en, tx_er, busy, underrun, s_if.s_ready_o} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: txd=%02h en=%0b er=%0b busy=%0b und=%0b rdy=%0b, required all 0",
               txd, tx_en, tx_er, busy, underrun, s_if.s_ready_o);
    end
    vectors++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt: %04h required 0000", frame_cnt);
    end
    s_if.s_valid_i = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || tx_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%0b en=%0b required 0 0", busy, tx_en);
    end
  endtask

  task automatic test_crc_check();
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
`ifdef GMII_TX_PAD_EN
    push_frame(9, 1'b1);
`else
    push_frame(9, 1'b0);
    exp_q.push_back(8'h26); exp_q.push_back(8'h39);
    exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
`endif
    en_cycles = 0;
    drive_frame(-1);
    s_if.s_valid_i = 1'b0;
    wait_done();
    exp_frames++;
    vectors++;
    if (en_cycles != exp_len(9)) begin
      errors++;
      $display("FAIL crc_en_len: Tx_en high %0d cycles, required %0d", en_cycles, exp_len(9));
    end
    vectors++;
    if (frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL crc_frame_cnt: %0d required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_pad();
    fill_payload(14, 3);
    push_frame(14, 1'b1);
    en_cycles = 0;
    drive_frame(-1);
    s_if.s_valid_i = 1'b0;
    wait_done();
    exp_frames++;
    vectors++;
    if (en_cycles != exp_len(14)) begin
      errors++;
      $display("FAIL pad_en_len: Tx_en high %0d cycles, required %0d", en_cycles, exp_len(14));
    end
    vectors++;
    if (frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL pad_frame_cnt: %0d required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_back_to_back();
    fill_payload(100, 11);
    push_frame(100, 1'b1);
    en_cycles = 0;
    last_gap  = 0;
    drive_frame(-1);
    fill_payload(100, 77);
    push_frame(100, 1'b1);
    drive_frame(-1);
    s_if.s_valid_i = 1'b0;
    wait_done();
    exp_frames += 16'd2;
    vectors++;
    if (last_gap != 13) begin
      errors++;
      $display("FAIL b2b_gap: Tx_en low %0d cycles between frames, required 13", last_gap);
    end
    vectors++;
    if (en_cycles != 2 * exp_len(100)) begin
      errors++;
      $display("FAIL b2b_en_len: Tx_en high %0d cycles, required %0d", en_cycles, 2 * exp_len(100));
    end
    vectors++;
    if (frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL b2b_frame_cnt: %0d required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_underrun();
    fill_payload(40, 5);
    push_frame(20, 1'b0);
    en_cycles = 0; er_cycles = 0; er_bad = 0; und_cnt = 0;
    drive_frame(20);
    s_if.s_valid_i = 1'b0;
    wait_done();
    vectors++;
    if (er_cycles != 1 || er_bad != 0) begin
      errors++;
      $display("FAIL underrun_er: Tx_er cycles=%0d nonzero_txd=%0d, required 1 and 0", er_cycles, er_bad);
    end
    vectors++;
    if (und_cnt != 1) begin
      errors++;
      $display("FAIL underrun_pulse: %0d pulses, required 1", und_cnt);
    end
    vectors++;
    if (en_cycles != 29) begin
      errors++;
      $display("FAIL underrun_en_len: Tx_en high %0d cycles, required 29", en_cycles);
    end
    vectors++;
    if (frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL underrun_frame_cnt: %0d required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    fill_payload(10, 9);
    push_frame(10, 1'b1);
    drive_frame(-1);
    s_if.s_valid_i = 1'b0;
    t = 0;
    while (exp_q.size() > 2 && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({txd, tx_en, tx_er, busy, underrun, s_if.s_ready_o} !== 14'd0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midreset_outputs: txd=%02h en=%0b er=%0b busy=%0b cnt=%04h, required all 0",
               txd, tx_en, tx_er, busy, frame_cnt);
    end
    exp_q.delete();
    exp_frames = 16'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_payload(70, 21);
    push_frame(70, 1'b1);
    en_cycles = 0;
    drive_frame(-1);
    s_if.s_valid_i = 1'b0;
    wait_done();
    exp_frames++;
    vectors++;
    if (en_cycles != exp_len(70) || frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL midreset_recover: en=%0d cnt=%0d, required %0d and %0d",
               en_cycles, frame_cnt, exp_len(70), exp_frames);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt_q;
    @(negedge clk);
    vectors++;
    if (frame_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: %04h required FFFF", frame_cnt);
    end
    fill_payload(60, 33);
    push_frame(60, 1'b1);
    drive_frame(-1);
    s_if.s_valid_i = 1'b0;
    wait_done();
    vectors++;
    if (frame_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_count: %04h required 0000", frame_cnt);
    end
  endtask

  initial begin
    s_if.s_data_i  = 8'h00;
    s_if.s_valid_i = 1'b0;
    s_if.s_last_i  = 1'b0;
    test_reset();
    test_crc_check();
    test_pad();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_wrap();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected bytes never transmitted, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
